// File: rtl/plic_reg_arbiter_pkg.sv
// Shared types, widths and the round-robin pick helper used by the PLIC
// register-interface arbiter and the other multi-master reg bridges.
package plic_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int REG_AW = 32;
  localparam int REG_DW = 32;
  localparam int REG_SW = 4;

  // Widest request vector the picker handles; narrower vectors are zero-extended.
  localparam int RR_MAX = 32;

  typedef struct packed {
    logic found;
    int   idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req, input int ptr, input int n);
    rr_pick_t r;
    int       k;
    r.found = 1'b0;
    r.idx   = 0;
    for (int off = 0; off < RR_MAX; off++) begin
      k = ptr + off;
      if (k >= n) begin
        k = k - n;
      end else begin
        k = k;
      end
      if ((off < n) && !r.found) begin
        if (req[k]) begin
          r.found = 1'b1;
          r.idx   = k;
        end else begin
          r.found = 1'b0;
        end
      end else begin
        r.found = r.found;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/plic_reg_arbiter_if.sv
// Bundles the N_REQ upstream reg masters and the single downstream PLIC reg
// port. Signal suffixes are seen from the arbiter's side.
interface plic_reg_arbiter_if
  import plic_arb_pkg::*;
#(
  parameter int N_REQ = 2
);
  logic [N_REQ*REG_AW-1:0] in_addr_i;
  logic [N_REQ-1:0]        in_write_i;
  logic [N_REQ*REG_DW-1:0] in_wdata_i;
  logic [N_REQ*REG_SW-1:0] in_wstrb_i;
  logic [N_REQ-1:0]        in_valid_i;
  logic [N_REQ-1:0]        in_ready_o;
  logic [N_REQ-1:0]        in_error_o;
  logic [REG_DW-1:0]       in_rdata_o;

  logic [REG_AW-1:0]       out_addr_o;
  logic                    out_write_o;
  logic [REG_DW-1:0]       out_wdata_o;
  logic [REG_SW-1:0]       out_wstrb_o;
  logic                    out_valid_o;
  logic [REG_DW-1:0]       out_rdata_i;
  logic                    out_error_i;
  logic                    out_ready_i;

  modport slave (
    input  in_addr_i, in_write_i, in_wdata_i, in_wstrb_i, in_valid_i,
    input  out_rdata_i, out_error_i, out_ready_i,
    output in_ready_o, in_error_o, in_rdata_o,
    output out_addr_o, out_write_o, out_wdata_o, out_wstrb_o, out_valid_o
  );

  modport master (
    output in_addr_i, in_write_i, in_wdata_i, in_wstrb_i, in_valid_i,
    output out_rdata_i, out_error_i, out_ready_i,
    input  in_ready_o, in_error_o, in_rdata_o,
    input  out_addr_o, out_write_o, out_wdata_o, out_wstrb_o, out_valid_o
  );

endinterface

// File: rtl/plic_reg_arbiter_rr.sv
// Combinational round-robin priority picker: first set request at or after ptr_i.
module rr_arbiter_idx
  import plic_arb_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [RR_MAX-1:0] req_ext_s;
  rr_pick_t          pick_s;

  always_comb begin
    req_ext_s              = {RR_MAX{1'b0}};
    req_ext_s[N_REQ-1:0]   = req_i;
    pick_s                 = rr_pick(req_ext_s, int'(ptr_i), N_REQ);
    idx_o                  = IDX_W'(pick_s.idx);
    valid_o                = pick_s.found;
  end

endmodule

// File: rtl/plic_reg_arbiter.sv
// Round-robin arbiter sharing one PLIC reg port among N_REQ masters; the grant
// is held for a whole transaction and hung accesses are aborted after TIMEOUT.
module plic_reg_arbiter
  import plic_arb_pkg::*;
#(
  parameter  int N_REQ   = 2,
  parameter  int TIMEOUT = 64,
  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1,
  localparam int IDX_W   = $clog2(N_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  plic_reg_arbiter_if.slave  bus,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_valid_s;
  logic [IDX_W-1:0] next_ptr_s;
  logic             gnt_valid_s;

  logic [N_REQ-1:0]  in_ready_s;
  logic [N_REQ-1:0]  in_error_s;
  logic [REG_DW-1:0] in_rdata_s;

  rr_arbiter_idx #(.N_REQ(N_REQ)) u_pick (
    .req_i   (bus.in_valid_i),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx_s),
    .valid_o (pick_valid_s)
  );

  assign next_ptr_s  = (gnt_idx_q == LAST_IDX) ? {IDX_W{1'b0}} : (gnt_idx_q + IDX_W'(1));
  assign gnt_valid_s = bus.in_valid_i[gnt_idx_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rr_ptr_q  <= {IDX_W{1'b0}};
      gnt_idx_q <= {IDX_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    gnt_idx_d       = gnt_idx_q;
    cnt_d           = cnt_q;
    in_ready_s      = {N_REQ{1'b0}};
    in_error_s      = {N_REQ{1'b0}};
    in_rdata_s      = {REG_DW{1'b0}};
    bus.out_addr_o  = {REG_AW{1'b0}};
    bus.out_write_o = 1'b0;
    bus.out_wdata_o = {REG_DW{1'b0}};
    bus.out_wstrb_o = {REG_SW{1'b0}};
    bus.out_valid_o = 1'b0;
    busy_o          = 1'b0;
    timeout_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          gnt_idx_d = pick_idx_s;
          cnt_d     = {CNT_W{1'b0}};
          state_d   = BUSY;
        end else begin
          state_d   = IDLE;
        end
      end
      BUSY: begin
        busy_o          = 1'b1;
        bus.out_addr_o  = bus.in_addr_i[int'(gnt_idx_q)*REG_AW +: REG_AW];
        bus.out_write_o = bus.in_write_i[gnt_idx_q];
        bus.out_wdata_o = bus.in_wdata_i[int'(gnt_idx_q)*REG_DW +: REG_DW];
        bus.out_wstrb_o = bus.in_wstrb_i[int'(gnt_idx_q)*REG_SW +: REG_SW];
        bus.out_valid_o = gnt_valid_s;
        // A master that withdraws its request mid-transaction loses the grant silently.
        if (!gnt_valid_s) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr_s;
        end else if (bus.out_ready_i) begin
          in_ready_s[gnt_idx_q] = 1'b1;
          in_error_s[gnt_idx_q] = bus.out_error_i;
          in_rdata_s            = bus.out_rdata_i;
          state_d               = IDLE;
          rr_ptr_d              = next_ptr_s;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          in_ready_s[gnt_idx_q] = 1'b1;
          in_error_s[gnt_idx_q] = 1'b1;
          timeout_o             = 1'b1;
          state_d               = IDLE;
          rr_ptr_d              = next_ptr_s;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready_o = in_ready_s;
  assign bus.in_error_o = in_error_s;
  assign bus.in_rdata_o = in_rdata_s;

endmodule

// File: tb/tb_plic_reg_arbiter.sv
// Directed bench for plic_reg_arbiter: stimulus pushes expected completions into
// a scoreboard queue that a separate monitor pops whenever in_ready_o fires.
module tb_plic_reg_arbiter;

  localparam int          N   = 2;
  localparam logic [31:0] JNK = 32'hDEAD_0000;

  logic clk;
  logic rst_i;
  logic busy_o;
  logic timeout_o;

  plic_reg_arbiter_if #(.N_REQ(N)) bus ();

  plic_reg_arbiter #(.N_REQ(N), .TIMEOUT(64)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .bus       (bus),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  typedef struct {
    int          idx;
    logic        err;
    logic [31:0] rdata;
    logic        to;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  int          m_req  [N];
  int          m_done [N];
  logic [31:0] m_addr [N];
  logic        m_write[N];
  logic [31:0] m_wdata[N];
  logic [3:0]  m_wstrb[N];
  logic        flush;

  int          slv_lat;
  logic        slv_hang;
  logic [31:0] slv_rdata;
  logic [31:0] slv_err_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Master agents: hold each request until its completion, then retire it.
  initial begin : driver
    logic [N-1:0] rdy;
    bus.in_addr_i  = '0;
    bus.in_write_i = '0;
    bus.in_wdata_i = '0;
    bus.in_wstrb_i = '0;
    bus.in_valid_i = '0;
    forever begin
      @(negedge clk);
      #3;
      rdy = bus.in_ready_o;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (flush) m_done[k] = m_req[k];
        else if (rdy[k]) m_done[k] = m_done[k] + 1;
        bus.in_valid_i[k]         = (m_req[k] != m_done[k]);
        bus.in_addr_i[k*32 +: 32] = m_addr[k];
        bus.in_write_i[k]         = m_write[k];
        bus.in_wdata_i[k*32 +: 32] = m_wdata[k];
        bus.in_wstrb_i[k*4 +: 4]  = m_wstrb[k];
      end
    end
  end

  // PLIC slave model: answers after slv_lat busy cycles, junk otherwise, stray ready in idle.
  initial begin : slave
    int vcnt;
    vcnt = 0;
    bus.out_ready_i = 1'b0;
    bus.out_error_i = 1'b0;
    bus.out_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (bus.out_valid_o) begin
        if (!slv_hang && vcnt >= slv_lat) begin
          bus.out_ready_i = 1'b1;
          bus.out_rdata_i = slv_rdata;
          bus.out_error_i = (bus.out_addr_o == slv_err_addr);
          vcnt = 0;
        end else begin
          bus.out_ready_i = 1'b0;
          bus.out_rdata_i = JNK;
          bus.out_error_i = 1'b1;
          vcnt++;
        end
      end else begin
        bus.out_ready_i = 1'b1;
        bus.out_rdata_i = JNK;
        bus.out_error_i = 1'b1;
        vcnt = 0;
      end
    end
  end

  // Monitor: every completion must match the oldest expected entry.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.in_ready_o != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 32'(bus.in_ready_o), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("ready_idx", 32'(bus.in_ready_o), 32'(1) << e.idx);
          chk("error", 32'(bus.in_error_o[e.idx]), 32'(e.err));
          chk("rdata", bus.in_rdata_o, e.rdata);
          chk("timeout_pulse", 32'(timeout_o), 32'(e.to));
          if (e.cyc >= 0) chk("latency", 32'(cyc), 32'(e.cyc));
        end
      end else if (timeout_o) begin
        chk("stray_timeout", 32'(timeout_o), 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'h0);
      sb.delete();
    end
    repeat (3) tick();
  endtask

  task automatic set_m(input int k, input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    m_addr[k]  = a;
    m_write[k] = w;
    m_wdata[k] = d;
    m_wstrb[k] = s;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    flush = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    flush = 1'b0;
    tick();
  endtask

  initial begin : stim
    int n;
    rst_i = 1'b1;
    flush = 1'b1;
    slv_lat = 0;
    slv_hang = 1'b0;
    slv_rdata = 32'h0;
    slv_err_addr = 32'hFFFF_FFFF;
    for (int k = 0; k < N; k++) begin
      m_req[k] = 0;
      m_done[k] = 0;
      set_m(k, 32'h0, 1'b0, 32'h0, 4'h0);
    end

    // Reset state, with the slave driving junk and a stray ready
    repeat (3) tick();
    #5;
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready_o), 32'h0);
    chk("rst_in_error", 32'(bus.in_error_o), 32'h0);
    chk("rst_in_rdata", bus.in_rdata_o, 32'h0);
    chk("rst_out_addr", bus.out_addr_o, 32'h0);
    chk("rst_timeout", 32'(timeout_o), 32'h0);
    tick();
    rst_i = 1'b0;
    flush = 1'b0;
    tick();
    #5;
    chk("idle_in_ready", 32'(bus.in_ready_o), 32'h0);
    chk("idle_in_rdata", bus.in_rdata_o, 32'h0);

    // T1: single read, slave waits 3 cycles
    tick();
    slv_lat = 3;
    slv_rdata = 32'h7;
    set_m(0, 32'h0C00_0004, 1'b0, 32'h0, 4'hF);
    m_req[0]++;
    sb.push_back('{0, 1'b0, 32'h7, 1'b0, cyc + 5});
    tick();
    #5;
    chk("arb_cycle_busy", 32'(busy_o), 32'h0);
    chk("arb_cycle_ready", 32'(bus.in_ready_o), 32'h0);
    tick();
    #5;
    chk("t1_out_valid", 32'(bus.out_valid_o), 32'h1);
    chk("t1_out_addr", bus.out_addr_o, 32'h0C00_0004);
    chk("t1_busy", 32'(busy_o), 32'h1);
    wait_drain(50);

    // T2: both masters continuously requesting from rr_ptr=0
    do_reset();
    tick();
    slv_lat = 0;
    slv_rdata = 32'h1234_5678;
    set_m(0, 32'h0C00_0100, 1'b0, 32'h0, 4'hF);
    set_m(1, 32'h0C00_0200, 1'b0, 32'h0, 4'hF);
    m_req[0] += 2;
    m_req[1] += 2;
    sb.push_back('{0, 1'b0, 32'h1234_5678, 1'b0, cyc + 2});
    sb.push_back('{1, 1'b0, 32'h1234_5678, 1'b0, cyc + 4});
    sb.push_back('{0, 1'b0, 32'h1234_5678, 1'b0, cyc + 6});
    sb.push_back('{1, 1'b0, 32'h1234_5678, 1'b0, cyc + 8});
    wait_drain(50);

    // T3: hung slave on master0, master1 waiting behind it
    tick();
    slv_hang = 1'b1;
    set_m(0, 32'h0C00_0300, 1'b0, 32'h0, 4'hF);
    set_m(1, 32'h0C00_0400, 1'b0, 32'h0, 4'hF);
    m_req[0]++;
    m_req[1]++;
    sb.push_back('{0, 1'b1, 32'h0, 1'b1, cyc + 65});
    sb.push_back('{1, 1'b0, 32'h1234_5678, 1'b0, -1});
    n = 0;
    while (sb.size() > 1 && n < 200) begin
      tick();
      n++;
    end
    slv_hang = 1'b0;
    wait_drain(50);

    // T4: ready arrives exactly on the last timeout cycle
    tick();
    slv_lat = 63;
    slv_rdata = 32'h55AA_55AA;
    set_m(0, 32'h0C00_0500, 1'b0, 32'h0, 4'hF);
    m_req[0]++;
    sb.push_back('{0, 1'b0, 32'h55AA_55AA, 1'b0, cyc + 65});
    wait_drain(200);

    // T5: write from master1 forwarded while master0 holds a read
    tick();
    slv_lat = 2;
    slv_rdata = 32'h0000_00A5;
    slv_err_addr = 32'h0C00_2000;
    set_m(0, 32'h0C00_1000, 1'b0, 32'h1111_1111, 4'hF);
    set_m(1, 32'h0C00_2000, 1'b1, 32'hDEAD_BEEF, 4'b0011);
    m_req[0]++;
    m_req[1]++;
    sb.push_back('{1, 1'b1, 32'h0000_00A5, 1'b0, -1});
    sb.push_back('{0, 1'b0, 32'h0000_00A5, 1'b0, -1});
    tick();
    tick();
    #5;
    chk("t5_out_valid", 32'(bus.out_valid_o), 32'h1);
    chk("t5_out_addr", bus.out_addr_o, 32'h0C00_2000);
    chk("t5_out_wdata", bus.out_wdata_o, 32'hDEAD_BEEF);
    chk("t5_out_wstrb", 32'(bus.out_wstrb_o), 32'h3);
    chk("t5_out_write", 32'(bus.out_write_o), 32'h1);
    wait_drain(50);

    // T6: reset in the middle of a hung transaction
    tick();
    slv_hang = 1'b1;
    slv_err_addr = 32'hFFFF_FFFF;
    slv_lat = 0;
    set_m(0, 32'h0C00_3000, 1'b0, 32'h0, 4'hF);
    m_req[0]++;
    tick();
    tick();
    #5;
    chk("t6_busy_before", 32'(busy_o), 32'h1);
    tick();
    rst_i = 1'b1;
    flush = 1'b1;
    tick();
    #5;
    chk("t6_out_valid", 32'(bus.out_valid_o), 32'h0);
    chk("t6_busy", 32'(busy_o), 32'h0);
    chk("t6_in_ready", 32'(bus.in_ready_o), 32'h0);
    tick();
    rst_i = 1'b0;
    flush = 1'b0;
    slv_hang = 1'b0;
    tick();
    set_m(0, 32'h0C00_4000, 1'b0, 32'h0, 4'hF);
    set_m(1, 32'h0C00_5000, 1'b0, 32'h0, 4'hF);
    m_req[0]++;
    m_req[1]++;
    sb.push_back('{0, 1'b0, 32'h0000_00A5, 1'b0, cyc + 2});
    sb.push_back('{1, 1'b0, 32'h0000_00A5, 1'b0, cyc + 4});
    wait_drain(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plic_reg_arbiter.md
Name: plic_reg_arbiter

Overview:
- Round-robin arbiter and sequencer that lets N_REQ register-interface masters share the single 32-bit reg_intf port of plic_top.
- Typical masters: the AXI→APB→reg path, a debug-module path and a boot-config engine.
- Holds the grant for one complete reg transaction (valid … ready).
- Aborts hung accesses with an error after a programmable timeout.
- Sits between the reg_intf masters and the plic_top req_i/resp_o pins.

Parameters:
- N_REQ, 2, number of requesting masters (≥2).
- TIMEOUT, 64, max cycles a granted access may wait for out_ready_i; 0 disables the timeout.
- CNT_W, $clog2(TIMEOUT+1), timeout counter width (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- in_addr_i  in  N_REQ*32  per-master address, master k at [32k+:32].
- in_write_i  in  N_REQ  per-master write flag.
- in_wdata_i  in  N_REQ*32  per-master write data.
- in_wstrb_i  in  N_REQ*4  per-master byte strobes.
- in_valid_i  in  N_REQ  per-master request valid.
- in_ready_o  out  N_REQ  per-master completion (one-hot or zero).
- in_error_o  out  N_REQ  per-master error, qualified by in_ready_o.
- in_rdata_o  out  32  read data broadcast to all masters, qualified by in_ready_o.
- out_addr_o  out  32  to PLIC req.addr.
- out_write_o  out  1  to PLIC req.write.
- out_wdata_o  out  32  to PLIC req.wdata.
- out_wstrb_o  out  4  to PLIC req.wstrb.
- out_valid_o  out  1  to PLIC req.valid.
- out_rdata_i  in  32  from PLIC resp.rdata.
- out_error_i  in  1  from PLIC resp.error.
- out_ready_i  in  1  from PLIC resp.ready.
- busy_o  out  1  high in BUSY.
- timeout_o  out  1  one-cycle pulse on abort.

Behaviour:
- Clocking: single clock domain. rst_i is synchronous, active-high.
- Reset state: IDLE, rr_ptr=0, gnt_idx=0, cnt=0.
- Outputs in reset and IDLE: out_valid_o=0, in_ready_o=0, in_error_o=0, busy_o=0, timeout_o=0. out_addr/wdata/wstrb/write and in_rdata_o are 0 in IDLE.
- IDLE:
  - If any in_valid_i is set, pick the first set index scanning rr_ptr, rr_ptr+1, … with mod-N_REQ wrap.
  - Register the pick into gnt_idx, clear cnt, go to BUSY.
  - No in_ready_o is asserted in the arbitration cycle.
- BUSY, forwarding:
  - out_* = in_*[gnt_idx], with out_valid_o = in_valid_i[gnt_idx]. This path is combinational.
  - Non-granted masters see in_ready_o=0 and must keep holding their requests.
- BUSY, completion (out_ready_i=1):
  - Same cycle: in_ready_o[gnt_idx]=1, in_error_o[gnt_idx]=out_error_i, in_rdata_o=out_rdata_i.
  - Next cycle: rr_ptr ← (gnt_idx+1) mod N_REQ, state → IDLE.
- BUSY, timeout (out_ready_i=0, TIMEOUT≠0 and cnt==TIMEOUT-1):
  - Same cycle: in_ready_o[gnt_idx]=1, in_error_o[gnt_idx]=1, in_rdata_o=0, timeout_o=1.
  - Next cycle: rr_ptr advances, state → IDLE.
  - Otherwise cnt increments each BUSY cycle, saturating.
- Ready and timeout in the same cycle: ready wins (normal completion, timeout_o=0).
- Granted master drops valid in BUSY (protocol violation): no ready is issued, state → IDLE next cycle, rr_ptr advances past gnt_idx.
- Late out_ready_i while out_valid_o=0 (in IDLE): ignored.
- Latency:
  - Request at cycle 0 → out_valid_o at cycle 1 → in_ready_o at cycle 1 with a zero-wait slave.
  - Back-to-back grants are separated by one IDLE cycle, so transactions start every ≥2 cycles.
- Fairness: a continuously requesting master waits at most N_REQ-1 transactions.
- rst_i asserted mid-transaction: in the next cycle the block is in IDLE, outputs are at reset values and the aborted requester receives no ready.

Decomposition:
- Shared package plic_arb_pkg holds:
  - arb_state_e {IDLE, BUSY};
  - localparams REG_AW=32, REG_DW=32, REG_SW=4;
  - function rr_pick(req, ptr) returning the index plus a found flag.
- One natural sub-module, rr_arbiter_idx: combinational round-robin priority picker (inputs req vector and ptr; outputs idx and valid). It is reused by other multi-master reg bridges in the SoC.

Test Plan:
- Single master, N_REQ=2: master0 reads addr 0x0C00_0004, slave ready after 3 cycles with rdata 0x7 → in_ready_o=01 at cycle 4, in_rdata_o=0x7, in_error_o=0.
- Both masters valid at cycle 0, rr_ptr=0: master0 is served first. Master1 is granted in the IDLE cycle after master0 completes, then served → completions ordered 0,1,0,1 over four continuous requests.
- Hung slave, TIMEOUT=64: out_ready_i held 0 → at cycle 64 of BUSY in_ready_o[gnt]=1, in_error_o=1, in_rdata_o=0, timeout_o pulses once; the next master is granted afterward.
- out_ready_i asserted in the same cycle cnt==TIMEOUT-1 with error=0 → normal completion, timeout_o=0, in_error_o=0.
- Write with wstrb=4'b0011, wdata=0xDEAD_BEEF from master1 → out_* exactly mirror master1 while BUSY; master0's concurrently held request is not forwarded.
- rst_i asserted during BUSY → next cycle out_valid_o=0, busy_o=0, rr_ptr=0, and no in_ready_o pulse is generated.
